ppu_vram_arbiter: RTL and testbench

- Single owner of the VRAM read/write port (0x8000–0x9FFF). Shares it between the background fetcher, the sprite fetcher and the CPU bus.
- Enforces the PPU mode-3 CPU lockout: blocked CPU reads return 0xFF and blocked writes are dropped.
- Tags every issued access with its owner and routes the returned byte plus a valid strobe back to that requester only.
- Sits between the PPU fetch datapath / CPU bus and the VRAM BRAM.

---
 rtl/ppu_vram_arbiter.sv | 131 +++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// VRAM port arbiter: shares the BRAM between BG fetcher, sprite fetcher and CPU,
// applies the mode-3 CPU lockout and routes read data back to the issuing requester.
module ppu_vram_arbiter #(
  parameter int          VRAM_AW  = 13,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               lcd_ena_in,
  input  logic [1:0]         mode_in,
  input  logic [15:0]        bg_addr_in,
  input  logic               bg_addr_valid_in,
  input  logic               bg_mem_busy_in,
  output logic [7:0]         bg_data_out,
  output logic               bg_data_valid_out,
  input  logic [15:0]        spr_addr_in,
  input  logic               spr_addr_valid_in,
  output logic [7:0]         spr_data_out,
  output logic               spr_data_valid_out,
  input  logic [15:0]        cpu_addr_in,
  input  logic               cpu_rd_in,
  input  logic               cpu_wr_in,
  input  logic [7:0]         cpu_wdata_in,
  output logic [7:0]         cpu_rdata_out,
  output logic               cpu_rdata_valid_out,
  output logic [VRAM_AW-1:0] vram_addr_out,
  output logic               vram_we_out,
  output logic [7:0]         vram_wdata_out,
  input  logic [7:0]         vram_rdata_in,
  output logic [1:0]         owner_out
);

  localparam int NREQ   = 3;
  localparam int STAGES = 2;
  localparam int R_CPU  = 0;
  localparam int R_BG   = 1;
  localparam int R_SPR  = 2;

  typedef enum logic [1:0] {OWN_CPU = 2'd0, OWN_BG = 2'd1, OWN_SPR = 2'd2} owner_e;

  owner_e owner_q;

  // Per-requester tags: a blocked CPU read can ride alongside a granted PPU read.
  logic [NREQ-1:0]              iss_vld, iss_ob;
  logic                         iss_we;
  logic [VRAM_AW-1:0]           iss_addr;
  logic [STAGES:1][NREQ-1:0]    vld_pipe, ob_pipe;
  logic [NREQ-1:0][7:0]         rdata_q;
  logic [NREQ-1:0]              rvld_q;

  function automatic logic in_vram(input logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  always_comb begin
    iss_vld  = '0;
    iss_ob   = '0;
    iss_we   = 1'b0;
    iss_addr = vram_addr_out;
    if (cpu_wr_in && owner_q == OWN_CPU && in_vram(cpu_addr_in)) begin
      iss_we   = 1'b1;
      iss_addr = cpu_addr_in[VRAM_AW-1:0];
    end
    if (cpu_rd_in) begin
      iss_vld[R_CPU] = 1'b1;
      iss_ob[R_CPU]  = cpu_wr_in || owner_q != OWN_CPU || !in_vram(cpu_addr_in);
      if (!iss_ob[R_CPU]) iss_addr = cpu_addr_in[VRAM_AW-1:0];
    end
    if (owner_q == OWN_BG && bg_addr_valid_in) begin
      iss_vld[R_BG] = 1'b1;
      iss_ob[R_BG]  = !in_vram(bg_addr_in);
      if (!iss_ob[R_BG]) iss_addr = bg_addr_in[VRAM_AW-1:0];
    end
    if (owner_q == OWN_SPR && spr_addr_valid_in) begin
      iss_vld[R_SPR] = 1'b1;
      iss_ob[R_SPR]  = !in_vram(spr_addr_in);
      if (!iss_ob[R_SPR]) iss_addr = spr_addr_in[VRAM_AW-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      owner_q        <= OWN_CPU;
      vram_addr_out  <= '0;
      vram_we_out    <= 1'b0;
      vram_wdata_out <= '0;
      vld_pipe       <= '0;
      ob_pipe        <= '0;
    end else begin
      if (!lcd_ena_in || mode_in != 2'd3) begin
        owner_q <= OWN_CPU;
      end else begin
        case (owner_q)
          OWN_CPU: owner_q <= bg_mem_busy_in ? OWN_BG : OWN_SPR;
          OWN_BG:  if (!bg_mem_busy_in && spr_addr_valid_in) owner_q <= OWN_SPR;
          OWN_SPR: if (bg_mem_busy_in) owner_q <= OWN_BG;
          default: owner_q <= OWN_CPU;
        endcase
      end
      vram_addr_out <= iss_addr;
      vram_we_out   <= iss_we;
      if (iss_we) vram_wdata_out <= cpu_wdata_in;
      vld_pipe[1] <= iss_vld;
      ob_pipe[1]  <= iss_ob;
      vld_pipe[2] <= vld_pipe[1];
      ob_pipe[2]  <= ob_pipe[1];
    end
  end

  // Stage 2 lines up with BRAM read data; unselected lanes keep their last byte.
  for (genvar r = 0; r < NREQ; r++) begin : g_ret
    always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
        rdata_q[r] <= '0;
        rvld_q[r]  <= 1'b0;
      end else begin
        rvld_q[r] <= vld_pipe[2][r];
        if (vld_pipe[2][r]) rdata_q[r] <= ob_pipe[2][r] ? OPEN_BUS : vram_rdata_in;
      end
    end
  end

  assign owner_out           = owner_q;
  assign cpu_rdata_out       = rdata_q[R_CPU];
  assign cpu_rdata_valid_out = rvld_q[R_CPU];
  assign bg_data_out         = rdata_q[R_BG];
  assign bg_data_valid_out   = rvld_q[R_BG];
  assign spr_data_out        = rdata_q[R_SPR];
  assign spr_data_valid_out  = rvld_q[R_SPR];

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with a 1-cycle-latency BRAM model.
module tb_ppu_vram_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_n_in, lcd_ena_in;
  logic [1:0]  mode_in;
  logic [15:0] bg_addr_in, spr_addr_in, cpu_addr_in;
  logic        bg_addr_valid_in, bg_mem_busy_in, spr_addr_valid_in;
  logic        cpu_rd_in, cpu_wr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  bg_data_out, spr_data_out, cpu_rdata_out;
  logic        bg_data_valid_out, spr_data_valid_out, cpu_rdata_valid_out;
  logic [12:0] vram_addr_out;
  logic        vram_we_out;
  logic [7:0]  vram_wdata_out, vram_rdata_in;
  logic [1:0]  owner_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [8192];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (vram_we_out) mem[vram_addr_out] <= vram_wdata_out;
    vram_rdata_in <= mem[vram_addr_out];
  end

  ppu_vram_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .lcd_ena_in(lcd_ena_in), .mode_in(mode_in),
    .bg_addr_in(bg_addr_in), .bg_addr_valid_in(bg_addr_valid_in), .bg_mem_busy_in(bg_mem_busy_in),
    .bg_data_out(bg_data_out), .bg_data_valid_out(bg_data_valid_out),
    .spr_addr_in(spr_addr_in), .spr_addr_valid_in(spr_addr_valid_in),
    .spr_data_out(spr_data_out), .spr_data_valid_out(spr_data_valid_out),
    .cpu_addr_in(cpu_addr_in), .cpu_rd_in(cpu_rd_in), .cpu_wr_in(cpu_wr_in),
    .cpu_wdata_in(cpu_wdata_in), .cpu_rdata_out(cpu_rdata_out),
    .cpu_rdata_valid_out(cpu_rdata_valid_out),
    .vram_addr_out(vram_addr_out), .vram_we_out(vram_we_out), .vram_wdata_out(vram_wdata_out),
    .vram_rdata_in(vram_rdata_in), .owner_out(owner_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic exp_we);
    cpu_addr_in = a; cpu_wdata_in = d; cpu_wr_in = 1'b1;
    tick();
    cpu_wr_in = 1'b0;
    chk("wr_we", 16'(vram_we_out), 16'(exp_we));
    if (exp_we) begin
      chk("wr_addr", 16'(vram_addr_out), 16'(a[12:0]));
      chk("wr_data", 16'(vram_wdata_out), 16'(d));
    end
    tick();
    chk("wr_we_pulse", 16'(vram_we_out), 16'h0);
  endtask

  // Read pulse at k; valid must be low at k+2 and high at k+3, then drop.
  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cpu_addr_in = a; cpu_rd_in = 1'b1;
    tick();
    cpu_rd_in = 1'b0;
    tick();
    chk({tag, "_early"}, 16'(cpu_rdata_valid_out), 16'h0);
    tick();
    chk({tag, "_vld"}, 16'(cpu_rdata_valid_out), 16'h1);
    chk({tag, "_data"}, 16'(cpu_rdata_out), 16'(exp));
    tick();
    chk({tag, "_vld_end"}, 16'(cpu_rdata_valid_out), 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    rst_n_in = 1'b0; lcd_ena_in = 1'b1; mode_in = 2'd0;
    bg_addr_in = '0; bg_addr_valid_in = 1'b0; bg_mem_busy_in = 1'b0;
    spr_addr_in = '0; spr_addr_valid_in = 1'b0;
    cpu_addr_in = '0; cpu_rd_in = 1'b0; cpu_wr_in = 1'b0; cpu_wdata_in = '0;
    repeat (3) tick();
    chk("rst_owner", 16'(owner_out), 16'h0);
    chk("rst_vld", {13'h0, cpu_rdata_valid_out, bg_data_valid_out, spr_data_valid_out}, 16'h0);
    chk("rst_we", 16'(vram_we_out), 16'h0);
    chk("rst_addr", 16'(vram_addr_out), 16'h0);
    rst_n_in = 1'b1;
    tick();

    // Mode 0: CPU owns VRAM
    cpu_write(16'h8010, 8'h5A, 1'b1);
    cpu_write(16'h9800, 8'h22, 1'b1);
    cpu_write(16'h8020, 8'hC3, 1'b1);
    cpu_write(16'h8100, 8'h3C, 1'b1);
    cpu_read("rd8010", 16'h8010, 8'h5A);
    chk("rd_addr", 16'(vram_addr_out), 16'h0010);
    cpu_read("rdA000", 16'hA000, 8'hFF);
    chk("oob_addr_hold", 16'(vram_addr_out), 16'h0010);
    // Simultaneous rd+wr: write lands, read sees open bus
    cpu_addr_in = 16'h8030; cpu_wdata_in = 8'h77; cpu_wr_in = 1'b1; cpu_rd_in = 1'b1;
    tick();
    cpu_wr_in = 1'b0; cpu_rd_in = 1'b0;
    chk("rdwr_we", 16'(vram_we_out), 16'h1);
    tick(); tick();
    chk("rdwr_vld", 16'(cpu_rdata_valid_out), 16'h1);
    chk("rdwr_data", 16'(cpu_rdata_out), 16'h00FF);
    tick();
    cpu_read("rd8030", 16'h8030, 8'h77);

    // Mode 3 lockout
    mode_in = 2'd3; bg_mem_busy_in = 1'b1;
    tick();
    chk("own_bg", 16'(owner_out), 16'h1);
    cpu_write(16'h9800, 8'h11, 1'b0);
    cpu_read("lock_rd", 16'h9800, 8'hFF);
    bg_addr_in = 16'h9800; bg_addr_valid_in = 1'b1;
    tick();
    bg_addr_valid_in = 1'b0;
    tick();
    chk("bg_early", 16'(bg_data_valid_out), 16'h0);
    tick();
    chk("bg_vld", 16'(bg_data_valid_out), 16'h1);
    chk("bg_old_data", 16'(bg_data_out), 16'h0022);
    chk("bg_no_cpu", 16'(cpu_rdata_valid_out), 16'h0);
    tick();
    chk("bg_vld_end", 16'(bg_data_valid_out), 16'h0);

    // BG out-of-range read
    bg_addr_in = 16'hA000; bg_addr_valid_in = 1'b1;
    tick();
    bg_addr_valid_in = 1'b0;
    chk("bg_oob_addr", 16'(vram_addr_out), 16'h1800);
    tick(); tick();
    chk("bg_oob_vld", 16'(bg_data_valid_out), 16'h1);
    chk("bg_oob_data", 16'(bg_data_out), 16'h00FF);
    tick();

    // Sprite handover: request at k ignored (BG still owns), k+1 granted
    bg_mem_busy_in = 1'b0; spr_addr_in = 16'h8020; spr_addr_valid_in = 1'b1;
    tick();
    chk("own_spr", 16'(owner_out), 16'h2);
    tick();
    spr_addr_valid_in = 1'b0;
    tick();
    chk("spr_ignored", 16'(spr_data_valid_out), 16'h0);
    tick();
    chk("spr_vld", 16'(spr_data_valid_out), 16'h1);
    chk("spr_data", 16'(spr_data_out), 16'h00C3);
    chk("spr_no_bg", 16'(bg_data_valid_out), 16'h0);
    chk("bg_hold", 16'(bg_data_out), 16'h00FF);
    tick();
    chk("spr_vld_end", 16'(spr_data_valid_out), 16'h0);
    bg_mem_busy_in = 1'b1;
    tick();
    chk("spr_to_bg", 16'(owner_out), 16'h1);

    // Mode exit with a BG read in flight
    bg_addr_in = 16'h8100; bg_addr_valid_in = 1'b1;
    tick();
    bg_addr_valid_in = 1'b0; mode_in = 2'd0;
    tick();
    chk("exit_owner", 16'(owner_out), 16'h0);
    cpu_addr_in = 16'h8010; cpu_rd_in = 1'b1;
    tick();
    cpu_rd_in = 1'b0;
    chk("exit_bg_vld", 16'(bg_data_valid_out), 16'h1);
    chk("exit_bg_data", 16'(bg_data_out), 16'h003C);
    tick(); tick();
    chk("exit_cpu_vld", 16'(cpu_rdata_valid_out), 16'h1);
    chk("exit_cpu_data", 16'(cpu_rdata_out), 16'h005A);
    tick();

    // LCD off in mode 3 keeps CPU owner
    lcd_ena_in = 1'b0; mode_in = 2'd3;
    tick(); tick();
    chk("lcd_off_owner", 16'(owner_out), 16'h0);
    lcd_ena_in = 1'b1;
    tick();
    chk("lcd_on_owner", 16'(owner_out), 16'h1);

    // Reset mid-stream kills in-flight reads
    bg_addr_in = 16'h8010; bg_addr_valid_in = 1'b1;
    tick(); tick();
    rst_n_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_bg_vld", 16'(bg_data_valid_out), 16'h0);
      chk("rst_own", 16'(owner_out), 16'h0);
    end
    bg_addr_valid_in = 1'b0; rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_vld", 16'(bg_data_valid_out), 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
